// File: rtl/iq_power_pkg.sv
// Shared constants, width helpers and the output-register state type for
// the I/Q power averager.
package iq_power_pkg;

  localparam int DEF_IQ_W     = 16;
  localparam int DEF_LOG2_AVG = 4;

  // The accumulator must hold 2^log2_avg full-scale powers without wrapping.
  function automatic int acc_width(input int n, input int log2_avg);
    return n + log2_avg;
  endfunction

  function automatic int cnt_width(input int log2_avg);
    return (log2_avg < 1) ? 1 : log2_avg;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/iq_power_square.sv
// Two-stage power pipeline: registered I^2 and Q^2, then their registered sum.
// p_valid follows in_valid by two clocks; rst/clear flush every stage.
module iq_power_square
  import iq_power_pkg::*;
#(
  parameter int IQ_W = DEF_IQ_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [IQ_W-1:0] in_i,
  input  logic signed [IQ_W-1:0] in_q,
  output logic [2*IQ_W-1:0]      p,
  output logic                   p_valid
);

  logic signed [2*IQ_W-1:0] prod_i;
  logic signed [2*IQ_W-1:0] prod_q;
  logic [2*IQ_W-1:0]        sq_i;
  logic [2*IQ_W-1:0]        sq_q;
  logic                     v1;

  // A square is never negative, so the signed product reinterprets losslessly.
  assign prod_i = in_i * in_i;
  assign prod_q = in_q * in_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sq_i    <= '0;
      sq_q    <= '0;
      v1      <= 1'b0;
      p       <= '0;
      p_valid <= 1'b0;
    end else begin
      v1      <= in_valid;
      p_valid <= v1;
      if (in_valid) begin
        sq_i <= unsigned'(prod_i);
        sq_q <= unsigned'(prod_q);
      end
      // Max sum is 2^(2*IQ_W-1), so 2*IQ_W bits never overflow.
      if (v1) begin
        p <= sq_i + sq_q;
      end
    end
  end

endmodule

// File: rtl/iq_power_averager.sv
// Averages I^2+Q^2 over 2^LOG2_AVG accepted samples and presents the floor
// of the mean on a valid/ready output register feeding the sqrt stage.
module iq_power_averager
  import iq_power_pkg::*;
#(
  parameter int IQ_W     = DEF_IQ_W,
  parameter int LOG2_AVG = DEF_LOG2_AVG,
  parameter int N        = 2 * IQ_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [IQ_W-1:0] in_i,
  input  logic signed [IQ_W-1:0] in_q,
  output logic [N-1:0]           out_power,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun
);

  localparam int ACC_W = acc_width(N, LOG2_AVG);
  localparam int CNT_W = cnt_width(LOG2_AVG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  if (N != 2 * IQ_W || (N % 2) != 0) begin : g_bad_n
    $error("iq_power_averager: N must equal 2*IQ_W and be even");
  end
  if (LOG2_AVG < 0 || LOG2_AVG > 8) begin : g_bad_log2
    $error("iq_power_averager: LOG2_AVG must be within 0..8");
  end

  logic [N-1:0]     p;
  logic             p_valid;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     block_mean;
  logic             block_done;
  out_state_t       state;
  out_state_t       state_next;
  logic             set_overrun;

  iq_power_square #(
    .IQ_W(IQ_W)
  ) u_square (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .in_valid(in_valid),
    .in_i    (in_i),
    .in_q    (in_q),
    .p       (p),
    .p_valid (p_valid)
  );

  assign acc_sum    = acc + ACC_W'(p);
  assign block_mean = N'(acc_sum >> LOG2_AVG);
  assign block_done = p_valid && (cnt == CNT_LAST);

  // Output handshake: a result transfers on any clock where out_valid and
  // out_ready are both high. out_valid is never withdrawn before transfer;
  // an unconsumed result may be replaced by a newer one, which sets overrun.
  always_comb begin
    state_next  = state;
    set_overrun = 1'b0;
    case (state)
      EMPTY: begin
        if (block_done) state_next = FULL;
      end
      FULL: begin
        if (block_done) set_overrun = !out_ready;
        else if (out_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= EMPTY;
      acc       <= '0;
      cnt       <= '0;
      out_power <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;
      if (set_overrun) overrun <= 1'b1;
      if (block_done) begin
        out_power <= block_mean;
        acc       <= '0;
        cnt       <= '0;
      end else if (p_valid) begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
